// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with 2-flop input synchroniser and 3-sample majority vote.
// Reports parity, framing, overrun and break status through a valid/ready holding register.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 rx_busy
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int M   = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] S_M1      = SW'(M - 1);
    localparam logic [SW-1:0] S_M       = SW'(M);
    localparam logic [SW-1:0] S_VOTE    = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIDX_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [TW-1:0]         cnt_q;
    logic [SW-1:0]         s_q, s_d;
    logic [BW-1:0]         bidx_q, bidx_d;
    logic [DATA_BITS-1:0]  sh_q, sh_d;
    logic [1:0]            smp_q, smp_d;
    logic                  pv_q, pv_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  stop0_q, stop0_d;
    logic                  busy_q, busy_d;
    logic                  armed_q, armed_d;
    logic                  done_q, done_d;
    logic                  line, tick, vote, at_vote, at_end, par_exp, brk, load;

    assign line    = sync2_q;
    assign tick    = (cnt_q == TICK_LAST);
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & line) | (smp_q[1] & line);
    assign at_vote = tick && (s_q == S_VOTE);
    assign at_end  = tick && (s_q == S_LAST);
    assign par_exp = (PARITY == 1) ? ~^sh_q : ^sh_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= rx_line;
            sync2_q <= sync1_q;
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
            smp_q   <= '0;
            pv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            stop0_q <= 1'b0;
            busy_q  <= 1'b0;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            smp_q   <= smp_d;
            pv_q    <= pv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            stop0_q <= stop0_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        bidx_d  = bidx_q;
        sh_d    = sh_q;
        smp_d   = smp_q;
        pv_d    = pv_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        stop0_d = stop0_q;
        busy_d  = busy_q;
        armed_d = armed_q;
        done_d  = 1'b0;

        if (tick && state_q != IDLE) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == S_M1) smp_d[0] = line;
            if (s_q == S_M)  smp_d[1] = line;
        end

        unique case (state_q)
            IDLE: begin
                if (line) armed_d = 1'b1;
                if (tick && !line && armed_q) begin
                    state_d = START;
                    s_d     = '0;
                    pv_d    = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    stop0_d = 1'b1;
                end
            end
            START: begin
                if (at_vote) begin
                    if (vote) state_d = IDLE;
                    else      busy_d  = 1'b1;
                end else if (at_end) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
            end
            DATA: begin
                if (at_vote) begin
                    sh_d   = {vote, sh_q[DATA_BITS-1:1]};
                    bidx_d = bidx_q + 1'b1;
                end else if (at_end && bidx_q == BIDX_DATA) begin
                    state_d = (PARITY != 0) ? PAR : STOP;
                    bidx_d  = '0;
                end
            end
            PAR: begin
                if (at_vote) begin
                    pv_d   = vote;
                    perr_d = (vote != par_exp);
                end else if (at_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (at_vote) begin
                    if (!vote) ferr_d = 1'b1;
                    stop0_d = stop0_q & ~vote;
                    if (bidx_q == LAST_STOP) begin
                        // A low final stop (break or framing fault) must see the line high before re-arming.
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        armed_d = vote;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign brk  = (sh_q == '0) && ((PARITY == 0) || !pv_q) && stop0_q;
    assign load = done_q && !brk && (!rx_valid || rx_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun_err <= done_q && !brk && rx_valid && !rx_ready;
            break_det   <= done_q && brk;
            if (load) begin
                rx_data    <= sh_q;
                rx_valid   <= 1'b1;
                parity_err <= perr_q;
                frame_err  <= ferr_q;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_busy = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) driven by directed and random frames,
// checked against a frame-level reference model.
module tb_uart_rx_cfg;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       line  [3];
    logic       rdy   [3];
    logic [7:0] data  [3];
    logic       valid [3];
    logic       perr  [3];
    logic       ferr  [3];
    logic       ovr   [3];
    logic       brk   [3];
    logic       busy  [3];

    int         nchk = 0;
    int         nfail = 0;
    logic [9:0] accq [3][$];
    int         ovr_cnt  [3];
    int         brk_cnt  [3];
    int         busy_cnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_rx_cfg #(
            .CLK_FREQ  (1536000),
            .BAUD_RATE (9600),
            .DATA_BITS (8),
            .PARITY    ((g == 1) ? 2 : 0),
            .STOP_BITS ((g == 2) ? 2 : 1),
            .OVERSAMPLE(16)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .rx_line    (line[g]),
            .rx_data    (data[g]),
            .rx_valid   (valid[g]),
            .rx_ready   (rdy[g]),
            .parity_err (perr[g]),
            .frame_err  (ferr[g]),
            .overrun_err(ovr[g]),
            .break_det  (brk[g]),
            .rx_busy    (busy[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid[k] && rdy[k]) accq[k].push_back({ferr[k], perr[k], data[k]});
            if (ovr[k])  ovr_cnt[k]++;
            if (brk[k])  brk_cnt[k]++;
            if (busy[k]) busy_cnt[k]++;
        end
    end

    task automatic chk(string tag, int obs, int exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(int k, logic b, int n);
        line[k] = b;
        step(n);
    endtask

    // Expected {frame_err, parity_err, data}; instance 1 uses even parity.
    function automatic logic [9:0] model(int k, logic [7:0] d, logic pbit, logic slast);
        logic pe;
        pe = (k == 1) && (pbit != 1'($countones(d) % 2));
        return {~slast, pe, d};
    endfunction

    task automatic send(int k, logic [7:0] d, logic pbit, logic slast, bit glitch);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (k == 1) bits.push_back(pbit);
        if (k == 2) bits.push_back(1'b1);
        bits.push_back(slast);
        foreach (bits[i]) begin
            if (glitch && i == 3) begin
                drive(k, bits[i], 80);
                drive(k, ~bits[i], 1);
                drive(k, bits[i], BIT_CLK - 81);
            end else begin
                drive(k, bits[i], BIT_CLK);
            end
        end
        line[k] = 1'b1;
    endtask

    task automatic expect_word(string tag, int k, logic [9:0] exp);
        step(BIT_CLK);
        chk({tag, "_count"}, accq[k].size(), 1);
        if (accq[k].size() > 0) chk(tag, accq[k].pop_front(), exp);
        accq[k].delete();
    endtask

    initial begin
        int         b0;
        logic [7:0] d;
        logic       pb, sl;

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            line[k] = 1'b1;
            rdy[k]  = 1'b1;
        end
        step(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_state_%0d", k),
                {valid[k], perr[k], ferr[k], ovr[k], brk[k], busy[k], data[k]}, 0);
        reset = 1'b0;
        step(2 * BIT_CLK);

        // 8N1 basic word
        send(0, 8'hA5, 1'b0, 1'b1, 1'b0);
        expect_word("t1_a5", 0, model(0, 8'hA5, 1'b0, 1'b1));

        // 8E1 parity wrong then right
        send(1, 8'h07, 1'b0, 1'b1, 1'b0);
        expect_word("t2_bad_par", 1, model(1, 8'h07, 1'b0, 1'b1));
        send(1, 8'h07, 1'b1, 1'b1, 1'b0);
        expect_word("t2_good_par", 1, model(1, 8'h07, 1'b1, 1'b1));

        // short low glitch is a false start; spike inside a data bit is outvoted
        b0 = busy_cnt[0];
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 3 * BIT_CLK);
        chk("t3_glitch_noword", accq[0].size(), 0);
        chk("t3_glitch_nobusy", busy_cnt[0] - b0, 0);
        send(0, 8'h6B, 1'b0, 1'b1, 1'b1);
        expect_word("t3_spike", 0, model(0, 8'h6B, 1'b0, 1'b1));

        // overrun with holding register full
        rdy[0] = 1'b0;
        b0 = ovr_cnt[0];
        send(0, 8'h11, 1'b0, 1'b1, 1'b0);
        step(BIT_CLK);
        send(0, 8'h22, 1'b0, 1'b1, 1'b0);
        step(BIT_CLK);
        chk("t4_held_valid", valid[0], 1);
        chk("t4_held_data", data[0], 8'h11);
        chk("t4_overrun_once", ovr_cnt[0] - b0, 1);
        rdy[0] = 1'b1;
        step(3);
        chk("t4_valid_cleared", valid[0], 0);
        chk("t4_accept_count", accq[0].size(), 1);
        if (accq[0].size() > 0) chk("t4_accept_word", accq[0].pop_front(), model(0, 8'h11, 1'b0, 1'b1));
        accq[0].delete();

        // break then recovery
        b0 = brk_cnt[0];
        drive(0, 1'b0, 12 * BIT_CLK);
        drive(0, 1'b1, 2 * BIT_CLK);
        chk("t5_break_once", brk_cnt[0] - b0, 1);
        chk("t5_break_noword", accq[0].size(), 0);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b0);
        expect_word("t5_after_break", 0, model(0, 8'h3C, 1'b0, 1'b1));

        // 8N2 with second stop low
        send(2, 8'h96, 1'b0, 1'b0, 1'b0);
        expect_word("t6_frame_err", 2, model(2, 8'h96, 1'b0, 1'b0));

        // reset in the middle of data bit 4
        d = 8'hA3;
        drive(2, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(2, d[i], BIT_CLK);
        drive(2, d[4], 80);
        chk("t6_busy_before_reset", busy[2], 1);
        reset   = 1'b1;
        line[2] = 1'b1;
        step(2);
        chk("t6_reset_outputs",
            {valid[2], perr[2], ferr[2], ovr[2], brk[2], busy[2], data[2]}, 0);
        reset = 1'b0;
        step(2 * BIT_CLK);
        chk("t6_no_stale_word", accq[2].size(), 0);
        send(2, 8'h5A, 1'b0, 1'b1, 1'b0);
        expect_word("t6_after_reset", 2, model(2, 8'h5A, 1'b0, 1'b1));

        // random frames on every configuration
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                d  = 8'($urandom);
                pb = 1'($urandom);
                sl = (k == 2) ? 1'($urandom) : 1'b1;
                send(k, d, pb, sl, 1'b0);
                expect_word($sformatf("rand_%0d_%0d", k, r), k, model(k, d, pb, sl));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
